// File: rtl/siso_4bit.sv
// Purpose : serial-in/serial-out shift register used as a fixed bit-delay line.
// Latency : a bit sampled on rising edge N is visible on so right after edge N+DEPTH-1.
// Backpr. : none; the register shifts on every rising edge while clear is low.
//
// Ports:
//   clk   - rising-edge clock
//   clear - asynchronous active-high clear, zeroes every stage
//   si    - serial data in, sampled on the rising edge of clk
//   so    - serial data out, driven directly by the last stage
//   q     - (only with SISO_PAR_OUT_EN defined) parallel view of all stages,
//           q[0] is the newest bit, q[DEPTH-1] equals so
//
// Optional feature macro: SISO_PAR_OUT_EN
`default_nettype none

module siso_4bit #(
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             si,
  output logic             so
`ifdef SISO_PAR_OUT_EN
  ,
  output logic [DEPTH-1:0] q
`endif
);

  // A one-stage "shift register" would collapse the slice below to nothing,
  // so such a configuration is refused while elaborating.
  if (DEPTH < 2) begin : g_bad_depth
    $error("siso_4bit: DEPTH must be >= 2");
  end

  logic [DEPTH-1:0] stage_q;
  logic [DEPTH-1:0] stage_d;

  // stage[0] is the input end; each edge moves every bit one stage towards so.
  always_comb begin
    stage_d = {stage_q[DEPTH-2:0], si};
  end

  // Clear is asynchronous so the line empties without a running clock.
  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  // Output is a pure register tap: no combinational path from si.
  assign so = stage_q[DEPTH-1];

`ifdef SISO_PAR_OUT_EN
  assign q = stage_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_siso_4bit.sv
`timescale 1ns/1ps

module tb_siso_4bit;

  logic clk;
  logic clear;
  logic si;
  logic so4;
  logic so8;
`ifdef SISO_PAR_OUT_EN
  logic [3:0] q4;
  logic [7:0] q8;
`endif

  int total;
  int bad;

  siso_4bit #(.DEPTH(4)) dut4 (
    .clk   (clk),
    .clear (clear),
    .si    (si),
    .so    (so4)
`ifdef SISO_PAR_OUT_EN
    ,
    .q     (q4)
`endif
  );

  siso_4bit #(.DEPTH(8)) dut8 (
    .clk   (clk),
    .clear (clear),
    .si    (si),
    .so    (so8)
`ifdef SISO_PAR_OUT_EN
    ,
    .q     (q8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: a bit delay line expressed as a queue. After a clear the
  // line holds DEPTH-1 zeros; each edge appends the sampled bit and the value
  // leaving the front is what so shows after that edge.
  logic dl4[$];
  logic dl8[$];
  logic recent[$];   // bits sampled since the last clear, newest at the back

  // Scoreboard queues: one expected value per rising edge.
  logic       exp4[$];
  logic       exp8[$];
  logic [7:0] expq8[$];

  function automatic logic [7:0] par_view();
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) begin
      if (i < recent.size()) v[i] = recent[recent.size() - 1 - i];
    end
    return v;
  endfunction

  task automatic model_clear();
    dl4.delete();
    dl8.delete();
    recent.delete();
    for (int i = 0; i < 3; i++) dl4.push_back(1'b0);
    for (int i = 0; i < 7; i++) dl8.push_back(1'b0);
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_so4"}, {7'd0, so4}, 8'd0);
    check({name, "_so8"}, {7'd0, so8}, 8'd0);
`ifdef SISO_PAR_OUT_EN
    check({name, "_q8"}, q8, 8'd0);
`endif
  endtask

  // One clock period of stimulus, driven on the falling edge.
  task automatic cycle(input logic b, input logic c);
    @(negedge clk);
    if (c && !clear) begin
      clear = 1'b1;
      si    = b;
      model_clear();
      #1;
      check_all_zero("async_clear");
    end else begin
      clear = c;
      si    = b;
    end
    if (c) begin
      model_clear();
      exp4.push_back(1'b0);
      exp8.push_back(1'b0);
      expq8.push_back(8'd0);
    end else begin
      dl4.push_back(b);
      dl8.push_back(b);
      recent.push_back(b);
      if (recent.size() > 8) void'(recent.pop_front());
      exp4.push_back(dl4.pop_front());
      exp8.push_back(dl8.pop_front());
      expq8.push_back(par_view());
    end
  endtask

  // Clear raised between edges, away from both clock edges.
  task automatic mid_clear();
    @(posedge clk);
    #2;
    clear = 1'b1;
    model_clear();
    #1;
    check_all_zero("mid_clear");
  endtask

  task automatic do_clear();
    cycle(1'b0, 1'b1);
  endtask

  // Monitor: every rising edge produces one output bit on each instance.
  initial begin
    logic       e;
    logic [7:0] eq;
    forever begin
      @(posedge clk);
      #1;
      if (exp4.size() > 0) begin
        e = exp4.pop_front();
        check("so4", {7'd0, so4}, {7'd0, e});
      end
      if (exp8.size() > 0) begin
        e = exp8.pop_front();
        check("so8", {7'd0, so8}, {7'd0, e});
      end
      if (expq8.size() > 0) begin
        eq = expq8.pop_front();
`ifdef SISO_PAR_OUT_EN
        check("q8", q8, eq);
        check("q4", {4'd0, q4}, {4'd0, eq[3:0]});
`endif
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    clear = 1'b0;
    si    = 1'b0;
    model_clear();

    // Reset and release.
    do_clear();
    cycle(1'b0, 1'b0);

    // Stream 0,1,1,0,1,0 then zeros.
    do_clear();
    begin
      logic [5:0] pat;
      pat = 6'b010110;  // LSB first: 0,1,1,0,1,0
      for (int i = 0; i < 6; i++) cycle(pat[i], 1'b0);
    end
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);

    // Single-cycle pulse latency.
    do_clear();
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0);

    // Parallel view / DEPTH=8: shift in 1,0,1,1.
    do_clear();
    cycle(1'b1, 1'b0);
    cycle(1'b0, 1'b0);
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
`ifdef SISO_PAR_OUT_EN
    @(posedge clk);
    #2;
    check("q8_after_4", q8, 8'b0000_1101);
`endif
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);

    // Mid-stream clear: full line of ones discarded.
    do_clear();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0);
    mid_clear();
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);

    // Clear held for 5 edges while si=1, then release with si=1.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      logic b;
      logic c;
      b = 1'($urandom_range(0, 1));
      c = ($urandom_range(0, 29) == 0);
      if (!clear && !c && ($urandom_range(0, 39) == 0)) mid_clear();
      cycle(b, c);
    end
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0);

    // Drain: every expected entry must have been consumed.
    @(posedge clk);
    #2;
    check("drain", 8'(exp4.size() + exp8.size() + expq8.size()), 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
